// File: rtl/plot_pkg.sv
// Shared constants and encodings for the plotting datapath: screen size, colours,
// note indices and FSM/operation encodings.
package plot_pkg;

   localparam int unsigned ScreenWidth  = 160;
   localparam int unsigned ScreenHeight = 120;

   localparam logic [2:0] BLACK = 3'b000;
   localparam logic [2:0] WHITE = 3'b111;
   localparam logic [2:0] GREEN = 3'b010;

   typedef enum logic [3:0] {
      NoteA4  = 4'd0,
      NoteAs4 = 4'd1,
      NoteB4  = 4'd2,
      NoteC5  = 4'd3,
      NoteCs5 = 4'd4,
      NoteD5  = 4'd5,
      NoteDs5 = 4'd6,
      NoteE5  = 4'd7,
      NoteF5  = 4'd8,
      NoteFs5 = 4'd9,
      NoteG5  = 4'd10,
      NoteGs5 = 4'd11,
      NoteA5  = 4'd12
   } note_e;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StClear  = 3'd1,
      StLetter = 3'd2,
      StGraph  = 3'd3,
      StDone   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      OpClear  = 2'd0,
      OpLetter = 2'd1,
      OpGraph  = 2'd2
   } op_e;

   // Clamp a requested bar level to the bar height.
   function automatic logic [6:0] sat_level(input logic [6:0] lvl, input logic [6:0] max_lvl);
      return (lvl >= max_lvl) ? max_lvl : lvl;
   endfunction

endpackage

// File: rtl/note_glyph_rom.sv
// 8x8 note-name glyph ROM. Bit 7 of a row is the leftmost pixel; sharps carry a
// small '#' at the right, A5 is underlined to tell it from A4.
module note_glyph_rom
   import plot_pkg::*;
(
   input  logic [3:0] note_idx,
   input  logic [2:0] row,
   output logic [7:0] glyph_row
);

   // Row 0 is the rightmost element of each concatenation.
   localparam logic [7:0][7:0] GlyphA = {8'h00, 8'h88, 8'h88, 8'h88, 8'hF8, 8'h88, 8'h88, 8'h70};
   localparam logic [7:0][7:0] GlyphB = {8'h00, 8'hF0, 8'h88, 8'h88, 8'hF0, 8'h88, 8'h88, 8'hF0};
   localparam logic [7:0][7:0] GlyphC = {8'h00, 8'h70, 8'h88, 8'h80, 8'h80, 8'h80, 8'h88, 8'h70};
   localparam logic [7:0][7:0] GlyphD = {8'h00, 8'hF0, 8'h88, 8'h88, 8'h88, 8'h88, 8'h88, 8'hF0};
   localparam logic [7:0][7:0] GlyphE = {8'h00, 8'hF8, 8'h80, 8'h80, 8'hF0, 8'h80, 8'h80, 8'hF8};
   localparam logic [7:0][7:0] GlyphF = {8'h00, 8'h80, 8'h80, 8'h80, 8'hF0, 8'h80, 8'h80, 8'hF8};
   localparam logic [7:0][7:0] GlyphG = {8'h00, 8'h78, 8'h88, 8'h88, 8'hB8, 8'h80, 8'h88, 8'h70};
   localparam logic [7:0][7:0] Sharp  = {8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h07, 8'h05, 8'h00};

   logic [7:0] base;
   logic       sharp;
   logic       underline;

   always_comb begin
      base      = 8'h00;
      sharp     = 1'b0;
      underline = 1'b0;
      case (note_idx)
         NoteA4:  base = GlyphA[row];
         NoteAs4: begin base = GlyphA[row]; sharp = 1'b1; end
         NoteB4:  base = GlyphB[row];
         NoteC5:  base = GlyphC[row];
         NoteCs5: begin base = GlyphC[row]; sharp = 1'b1; end
         NoteD5:  base = GlyphD[row];
         NoteDs5: begin base = GlyphD[row]; sharp = 1'b1; end
         NoteE5:  base = GlyphE[row];
         NoteF5:  base = GlyphF[row];
         NoteFs5: begin base = GlyphF[row]; sharp = 1'b1; end
         NoteG5:  base = GlyphG[row];
         NoteGs5: begin base = GlyphG[row]; sharp = 1'b1; end
         NoteA5:  begin base = GlyphA[row]; underline = 1'b1; end
         default: base = 8'h00;
      endcase
   end

   always_comb begin
      glyph_row = base;
      if (sharp) begin
         glyph_row = base | Sharp[row];
      end
      if (underline && (row == 3'd7)) begin
         glyph_row = 8'hF8;
      end
   end

endmodule

// File: rtl/plot_datapath.sv
// Pixel generator for the plotting controller: full-screen clear, note glyph and
// level bar, one registered pixel per clock with a done pulse per operation.
module plot_datapath
   import plot_pkg::*;
#(
   parameter int unsigned SCREEN_W     = ScreenWidth,
   parameter int unsigned SCREEN_H     = ScreenHeight,
   parameter int unsigned LETTER_X     = 8,
   parameter int unsigned LETTER_Y     = 8,
   parameter int unsigned GRAPH_X0     = 40,
   parameter int unsigned GRAPH_Y_BASE = 110,
   parameter int unsigned BAR_W        = 8,
   parameter int unsigned GRAPH_H      = 64
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ld_clear,
   input  logic       ld_letter,
   input  logic       ld_graph,
   input  logic [3:0] note_idx,
   input  logic [6:0] level,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       done_clear,
   output logic       done_plot_letter,
   output logic       done_plot_graph
);

   state_e     state_q, state_d;
   op_e        op_q, op_d;
   logic [7:0] cx_q, cx_d;
   logic [6:0] cy_q, cy_d;
   logic [3:0] note_q, note_d;
   logic [6:0] level_q, level_d;

   logic [7:0] x_last;
   logic [6:0] y_last;
   logic       last_px;
   logic       ld_act;
   logic [7:0] glyph_row;

   logic [7:0] x_d;
   logic [6:0] y_d;
   logic [2:0] colour_d;
   logic       plot_d;
   logic       done_clear_d, done_letter_d, done_graph_d;

   note_glyph_rom u_rom (
      .note_idx  (note_q),
      .row       (cy_q[2:0]),
      .glyph_row (glyph_row)
   );

   always_comb begin
      x_last = 8'd0;
      y_last = 7'd0;
      ld_act = 1'b0;
      case (state_q)
         StClear: begin
            x_last = 8'(SCREEN_W - 1);
            y_last = 7'(SCREEN_H - 1);
            ld_act = ld_clear;
         end
         StLetter: begin
            x_last = 8'd7;
            y_last = 7'd7;
            ld_act = ld_letter;
         end
         StGraph: begin
            x_last = 8'(BAR_W - 1);
            y_last = 7'(GRAPH_H - 1);
            ld_act = ld_graph;
         end
         default: ;
      endcase
   end

   assign last_px = (cx_q == x_last) && (cy_q == y_last);

   // State and counter registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         op_q    <= OpClear;
         cx_q    <= 8'd0;
         cy_q    <= 7'd0;
         note_q  <= 4'd0;
         level_q <= 7'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         note_q  <= note_d;
         level_q <= level_d;
      end
   end

   // Next-state and counter stepping
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      note_d  = note_q;
      level_d = level_q;
      case (state_q)
         StIdle: begin
            cx_d = 8'd0;
            cy_d = 7'd0;
            if (ld_clear) begin
               state_d = StClear;
               op_d    = OpClear;
            end else if (ld_letter) begin
               state_d = StLetter;
               op_d    = OpLetter;
               note_d  = note_idx;
            end else if (ld_graph) begin
               state_d = StGraph;
               op_d    = OpGraph;
               level_d = sat_level(level, 7'(GRAPH_H));
            end
         end
         StClear, StLetter, StGraph: begin
            if (!ld_act) begin
               state_d = StIdle;
            end else if (last_px) begin
               state_d = StDone;
            end else if (cx_q == x_last) begin
               cx_d = 8'd0;
               cy_d = cy_q + 7'd1;
            end else begin
               cx_d = cx_q + 8'd1;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Pixel and done outputs, computed for the current state and registered below
   always_comb begin
      x_d           = x;
      y_d           = y;
      colour_d      = colour;
      plot_d        = 1'b0;
      done_clear_d  = 1'b0;
      done_letter_d = 1'b0;
      done_graph_d  = 1'b0;
      case (state_q)
         StClear: begin
            if (ld_clear) begin
               plot_d   = 1'b1;
               x_d      = cx_q;
               y_d      = cy_q;
               colour_d = BLACK;
            end
         end
         StLetter: begin
            if (ld_letter) begin
               plot_d   = 1'b1;
               x_d      = 8'(LETTER_X) + cx_q;
               y_d      = 7'(LETTER_Y) + cy_q;
               colour_d = glyph_row[3'd7 - cx_q[2:0]] ? WHITE : BLACK;
            end
         end
         StGraph: begin
            if (ld_graph) begin
               plot_d   = 1'b1;
               x_d      = 8'(GRAPH_X0) + cx_q;
               y_d      = 7'(GRAPH_Y_BASE) - cy_q;
               colour_d = (cy_q < level_q) ? GREEN : BLACK;
            end
         end
         StDone: begin
            done_clear_d  = (op_q == OpClear);
            done_letter_d = (op_q == OpLetter);
            done_graph_d  = (op_q == OpGraph);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x                <= 8'd0;
         y                <= 7'd0;
         colour           <= BLACK;
         plot             <= 1'b0;
         done_clear       <= 1'b0;
         done_plot_letter <= 1'b0;
         done_plot_graph  <= 1'b0;
      end else begin
         x                <= x_d;
         y                <= y_d;
         colour           <= colour_d;
         plot             <= plot_d;
         done_clear       <= done_clear_d;
         done_plot_letter <= done_letter_d;
         done_plot_graph  <= done_graph_d;
      end
   end

endmodule
